nx_stream_arbiter: RTL and testbench

// Shares one node_message_t outbound stream between INPUTS inbound streams.

---
 rtl/nx_stream_arbiter.sv | 125 ++++++++++++
 tb/tb_nx_stream_arbiter.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nx_stream_arbiter.sv
// nx_stream_arbiter
//
// Shares one outbound message stream between INPUTS inbound streams. The
// arbiter uses round-robin selection with an optional burst allowance: a
// requester may keep the grant for up to BURST consecutive messages while it
// stays valid, and then the grant rotates. The output is one registered stage,
// so it carries one message per cycle when downstream never stalls.
//
// Handshake rule: a transfer happens on a clock edge where valid and ready are
// both high. Valid never depends on ready. The only combinational path from
// valid to ready is through the winner selection that drives o_inbound_ready.
//
// Ports
//   i_clk            clock
//   i_rst            asynchronous, active-high reset
//   i_inbound_data   INPUTS messages of W bits; requester k uses [k*W +: W]
//   i_inbound_valid  per-requester valid
//   o_inbound_ready  per-requester ready (one-hot or zero)
//   o_outbound_data  registered message
//   o_outbound_valid registered valid
//   i_outbound_ready downstream ready
//   o_grant_id       index of the most recently accepted requester
//   o_idle           no buffered message and no inbound valid
module nx_stream_arbiter #(
    parameter int INPUTS = 4,
    parameter int BURST  = 1,
    parameter int W      = 8,
    localparam int IDW   = (INPUTS > 1) ? $clog2(INPUTS) : 1,
    localparam int BW    = (BURST > 1) ? $clog2(BURST) : 1
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic [INPUTS*W-1:0] i_inbound_data,
    input  logic [INPUTS-1:0]   i_inbound_valid,
    output logic [INPUTS-1:0]   o_inbound_ready,
    output logic [W-1:0]        o_outbound_data,
    output logic                o_outbound_valid,
    input  logic                i_outbound_ready,
    output logic [IDW-1:0]      o_grant_id,
    output logic                o_idle
);

    logic [W-1:0]   data_q,  data_d;
    logic           valid_q, valid_d;
    logic [IDW-1:0] last_q,  last_d;
    logic [BW-1:0]  burst_q, burst_d;

    logic           load_ok;
    logic           any_valid;
    logic           hold;
    logic           found;
    logic [IDW-1:0] winner;
    logic [IDW-1:0] idx;

    assign load_ok   = !valid_q || i_outbound_ready;
    assign any_valid = |i_inbound_valid;

    // Winner selection. burst_q counts extra grants beyond the first in the
    // current run, so holding is allowed while it is below BURST-1. When not
    // holding, the scan starts just after last_q and ends at last_q itself,
    // so the previous winner is considered only after everyone else.
    always_comb begin
        hold   = 1'b0;
        found  = 1'b0;
        winner = last_q;
        idx    = last_q;
        if (BURST > 1 && INPUTS > 1) begin
            hold = i_inbound_valid[last_q] && (int'(burst_q) < BURST - 1);
        end
        if (!hold) begin
            for (int k = 1; k <= INPUTS; k++) begin
                idx = IDW'((int'(last_q) + k) % INPUTS);
                if (!found && i_inbound_valid[idx]) begin
                    winner = idx;
                    found  = 1'b1;
                end
            end
        end
    end

    always_comb begin
        o_inbound_ready = '0;
        if (load_ok && any_valid) begin
            o_inbound_ready[winner] = 1'b1;
        end
    end

    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        last_d  = last_q;
        burst_d = burst_q;
        if (load_ok) begin
            if (any_valid) begin
                data_d  = i_inbound_data[int'(winner)*W +: W];
                valid_d = 1'b1;
                last_d  = winner;
                burst_d = hold ? burst_q + BW'(1) : '0;
            end else begin
                // Nothing to load: the stage drains if downstream takes it.
                valid_d = i_outbound_ready ? 1'b0 : valid_q;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= IDW'(INPUTS - 1);
            burst_q <= '0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            burst_q <= burst_d;
        end
    end

    assign o_outbound_data  = data_q;
    assign o_outbound_valid = valid_q;
    assign o_grant_id       = last_q;
    assign o_idle           = !valid_q && !any_valid;

endmodule

// File: tb/tb_nx_stream_arbiter.sv
module tb_nx_stream_arbiter;

  typedef struct {
    logic [3:0] valid;
    logic       oready;
    logic [3:0] exp_rdy;
    logic [1:0] exp_gid;
    logic       exp_ov;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] in_data;
  logic [3:0]  in_valid;
  logic        out_ready;

  logic [3:0]  rdy_o  [3];
  logic [7:0]  od_o   [3];
  logic        ov_o   [3];
  logic [1:0]  gid_o  [3];
  logic        idle_o [3];

  int checks = 0;
  int failures = 0;

  // reference model state, one per instance (BURST = 1, 3, 4)
  int          bl      [3] = '{1, 3, 4};
  int          m_last  [3];
  int          m_run   [3];
  bit          m_valid [3];
  logic [7:0]  m_data  [3];

  vec_t tbl [13];

  always #5 clk = ~clk;

  nx_stream_arbiter #(.INPUTS(4), .BURST(1), .W(8)) dut_b1 (
    .i_clk(clk), .i_rst(rst), .i_inbound_data(in_data), .i_inbound_valid(in_valid),
    .o_inbound_ready(rdy_o[0]), .o_outbound_data(od_o[0]), .o_outbound_valid(ov_o[0]),
    .i_outbound_ready(out_ready), .o_grant_id(gid_o[0]), .o_idle(idle_o[0]));

  nx_stream_arbiter #(.INPUTS(4), .BURST(3), .W(8)) dut_b3 (
    .i_clk(clk), .i_rst(rst), .i_inbound_data(in_data), .i_inbound_valid(in_valid),
    .o_inbound_ready(rdy_o[1]), .o_outbound_data(od_o[1]), .o_outbound_valid(ov_o[1]),
    .i_outbound_ready(out_ready), .o_grant_id(gid_o[1]), .o_idle(idle_o[1]));

  nx_stream_arbiter #(.INPUTS(4), .BURST(4), .W(8)) dut_b4 (
    .i_clk(clk), .i_rst(rst), .i_inbound_data(in_data), .i_inbound_valid(in_valid),
    .o_inbound_ready(rdy_o[2]), .o_outbound_data(od_o[2]), .o_outbound_valid(ov_o[2]),
    .i_outbound_ready(out_ready), .o_grant_id(gid_o[2]), .o_idle(idle_o[2]));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 4'b0;
    in_data = 32'h0;
    out_ready = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  function automatic logic [7:0] byte_of(int k);
    logic [31:0] d;
    d = in_data;
    return d[k*8 +: 8];
  endfunction

  // ---------------- reference model ----------------
  // Reset behaves as if requester 3 had just received one grant.
  function automatic void model_reset();
    for (int m = 0; m < 3; m++) begin
      m_last[m] = 3;
      m_run[m] = 1;
      m_valid[m] = 1'b0;
      m_data[m] = 8'h0;
    end
  endfunction

  // m_run = length of the current run of consecutive grants to m_last.
  function automatic int pick(int m, logic [3:0] v, output bit held);
    int j;
    held = 1'b0;
    if (v[2'(m_last[m])] && m_run[m] < bl[m]) begin
      held = 1'b1;
      return m_last[m];
    end
    for (int k = 1; k <= 4; k++) begin
      j = (m_last[m] + k) % 4;
      if (v[2'(j)]) return j;
    end
    return -1;
  endfunction

  function automatic logic [3:0] model_rdy(int m);
    bit h;
    int w;
    if ((!m_valid[m] || out_ready) && (in_valid != 4'b0)) begin
      w = pick(m, in_valid, h);
      return 4'b0001 << w;
    end
    return 4'b0000;
  endfunction

  function automatic void model_step();
    bit h;
    int w;
    for (int m = 0; m < 3; m++) begin
      if (!m_valid[m] || out_ready) begin
        if (in_valid != 4'b0) begin
          w = pick(m, in_valid, h);
          m_run[m] = h ? m_run[m] + 1 : 1;
          m_last[m] = w;
          m_valid[m] = 1'b1;
          m_data[m] = byte_of(w);
        end else begin
          m_valid[m] = 1'b0;
        end
      end
    end
  endfunction

  initial begin
    bit rst_now;

    // ---- reset state ----
    rst = 1'b1;
    in_valid = 4'b0;
    in_data = 32'h0;
    out_ready = 1'b1;
    settle();
    for (int m = 0; m < 3; m++) begin
      chk($sformatf("reset_ov[%0d]", m), 32'(ov_o[m]), 32'd0);
      chk($sformatf("reset_od[%0d]", m), 32'(od_o[m]), 32'h0);
      chk($sformatf("reset_gid[%0d]", m), 32'(gid_o[m]), 32'd3);
      chk($sformatf("reset_idle[%0d]", m), 32'(idle_o[m]), 32'd1);
    end

    // ---- round robin, all valid, BURST=1 ----
    do_reset();
    in_data = 32'hA3A2A1A0;
    in_valid = 4'b1111;
    settle();
    chk("rr_ov_before_first_edge", 32'(ov_o[0]), 32'd0);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk($sformatf("rr_gid[%0d]", i), 32'(gid_o[0]), 32'(i % 4));
      chk($sformatf("rr_ov[%0d]", i), 32'(ov_o[0]), 32'd1);
      chk($sformatf("rr_od[%0d]", i), 32'(od_o[0]), 32'(8'hA0 + i % 4));
    end

    // ---- table: BURST=3, inputs 0 and 2 ----
    tbl[0]  = '{4'b0101, 1'b1, 4'b0001, 2'd0, 1'b1};
    tbl[1]  = '{4'b0101, 1'b1, 4'b0001, 2'd0, 1'b1};
    tbl[2]  = '{4'b0101, 1'b1, 4'b0001, 2'd0, 1'b1};
    tbl[3]  = '{4'b0101, 1'b1, 4'b0100, 2'd2, 1'b1};
    tbl[4]  = '{4'b0101, 1'b1, 4'b0100, 2'd2, 1'b1};
    tbl[5]  = '{4'b0101, 1'b1, 4'b0100, 2'd2, 1'b1};
    tbl[6]  = '{4'b0101, 1'b1, 4'b0001, 2'd0, 1'b1};
    tbl[7]  = '{4'b0101, 1'b1, 4'b0001, 2'd0, 1'b1};
    tbl[8]  = '{4'b0101, 1'b1, 4'b0001, 2'd0, 1'b1};
    tbl[9]  = '{4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0};
    tbl[10] = '{4'b0101, 1'b0, 4'b0100, 2'd2, 1'b1};
    tbl[11] = '{4'b0101, 1'b0, 4'b0000, 2'd2, 1'b1};
    tbl[12] = '{4'b0101, 1'b1, 4'b0100, 2'd2, 1'b1};
    do_reset();
    in_data = 32'h44332211;
    for (int i = 0; i < 13; i++) begin
      in_valid = tbl[i].valid;
      out_ready = tbl[i].oready;
      settle();
      chk($sformatf("tbl_rdy[%0d]", i), 32'(rdy_o[1]), 32'(tbl[i].exp_rdy));
      tick();
      chk($sformatf("tbl_gid[%0d]", i), 32'(gid_o[1]), 32'(tbl[i].exp_gid));
      chk($sformatf("tbl_ov[%0d]", i), 32'(ov_o[1]), 32'(tbl[i].exp_ov));
    end

    // ---- backpressure: input 1 only, BURST=1 ----
    do_reset();
    in_data = 32'h00005A00;
    in_valid = 4'b0010;
    out_ready = 1'b0;
    tick();
    in_data = 32'h00006B00;
    for (int i = 0; i < 5; i++) begin
      settle();
      chk($sformatf("bp_rdy[%0d]", i), 32'(rdy_o[0]), 32'h0);
      tick();
      chk($sformatf("bp_ov[%0d]", i), 32'(ov_o[0]), 32'd1);
      chk($sformatf("bp_od[%0d]", i), 32'(od_o[0]), 32'h5A);
    end
    out_ready = 1'b1;
    settle();
    chk("bp_release_rdy", 32'(rdy_o[0]), 32'b0010);
    tick();
    chk("bp_next_od", 32'(od_o[0]), 32'h6B);
    chk("bp_next_ov", 32'(ov_o[0]), 32'd1);
    in_valid = 4'b0000;
    tick();
    chk("bp_drained_ov", 32'(ov_o[0]), 32'd0);
    chk("bp_drained_idle", 32'(idle_o[0]), 32'd1);

    // ---- wrap from 3 to 0, BURST=1 ----
    do_reset();
    in_data = 32'h0D0C0B0A;
    in_valid = 4'b1000;
    tick();
    chk("wrap_first_gid", 32'(gid_o[0]), 32'd3);
    in_valid = 4'b1001;
    tick();
    chk("wrap_second_gid", 32'(gid_o[0]), 32'd0);
    tick();
    chk("wrap_third_gid", 32'(gid_o[0]), 32'd3);
    chk("wrap_third_od", 32'(od_o[0]), 32'h0D);

    // ---- held requester drops mid-burst, BURST=4 ----
    do_reset();
    in_data = 32'h33221100;
    in_valid = 4'b0100;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("drop_hold_gid[%0d]", i), 32'(gid_o[2]), 32'd2);
    end
    in_valid = 4'b1010;
    settle();
    chk("drop_rdy", 32'(rdy_o[2]), 32'b1000);
    tick();
    chk("drop_gid_3", 32'(gid_o[2]), 32'd3);
    in_valid = 4'b0010;
    tick();
    chk("drop_gid_1", 32'(gid_o[2]), 32'd1);
    chk("drop_od_1", 32'(od_o[2]), 32'h11);

    // ---- reset mid-operation ----
    do_reset();
    in_data = 32'h77665544;
    in_valid = 4'b0111;
    out_ready = 1'b0;
    tick();
    tick();
    for (int m = 0; m < 3; m++) chk($sformatf("mid_pre_ov[%0d]", m), 32'(ov_o[m]), 32'd1);
    rst = 1'b1;
    settle();
    for (int m = 0; m < 3; m++) begin
      chk($sformatf("mid_rst_ov[%0d]", m), 32'(ov_o[m]), 32'd0);
      chk($sformatf("mid_rst_idle_busy[%0d]", m), 32'(idle_o[m]), 32'd0);
    end
    in_valid = 4'b0000;
    settle();
    for (int m = 0; m < 3; m++) chk($sformatf("mid_rst_idle_quiet[%0d]", m), 32'(idle_o[m]), 32'd1);
    tick();
    in_valid = 4'b0111;
    rst = 1'b0;
    tick();
    for (int m = 0; m < 3; m++) begin
      chk($sformatf("mid_after_gid[%0d]", m), 32'(gid_o[m]), 32'd0);
      chk($sformatf("mid_after_od[%0d]", m), 32'(od_o[m]), 32'h44);
    end

    // ---- randomized against reference model ----
    do_reset();
    model_reset();
    for (int c = 0; c < 600; c++) begin
      for (int m = 0; m < 3; m++) begin
        chk($sformatf("rnd_ov[%0d][%0d]", c, m), 32'(ov_o[m]), 32'(m_valid[m]));
        chk($sformatf("rnd_od[%0d][%0d]", c, m), 32'(od_o[m]), 32'(m_data[m]));
        chk($sformatf("rnd_gid[%0d][%0d]", c, m), 32'(gid_o[m]), 32'(m_last[m]));
      end
      in_valid = 4'($urandom_range(0, 15));
      in_data = $urandom;
      out_ready = ($urandom_range(0, 3) != 0);
      rst_now = ($urandom_range(0, 49) == 0);
      rst = rst_now;
      if (rst_now) model_reset();
      settle();
      for (int m = 0; m < 3; m++) begin
        chk($sformatf("rnd_rdy[%0d][%0d]", c, m), 32'(rdy_o[m]), 32'(model_rdy(m)));
        chk($sformatf("rnd_idle[%0d][%0d]", c, m), 32'(idle_o[m]),
            32'(!m_valid[m] && (in_valid == 4'b0)));
      end
      if (!rst_now) model_step();
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
